// File: rtl/expr_pkg.sv
// rtl/expr_pkg.sv - shared ASCII constants, character classifiers and evaluator state encoding
//
// Imported by the expression evaluator (and by the legality checker that runs alongside it).
// Contents:
//   CH_*            ASCII codes of the characters the grammar uses
//   is_digit/is_op  character class tests
//   eval_state_e    3-bit evaluator state encoding
package expr_pkg;

    localparam logic [7:0] CH_0   = 8'h30;
    localparam logic [7:0] CH_9   = 8'h39;
    localparam logic [7:0] CH_ADD = 8'h2B;
    localparam logic [7:0] CH_MUL = 8'h2A;
    localparam logic [7:0] CH_LP  = 8'h28;
    localparam logic [7:0] CH_RP  = 8'h29;

    typedef enum logic [2:0] {
        O_OPND = 3'd0,  // outside parens, expecting an operand or '('
        O_OPR  = 3'd1,  // outside parens, expecting an operator
        I_OPND = 3'd2,  // inside parens, expecting an operand
        I_OPR  = 3'd3,  // inside parens, expecting an operator or ')'
        ERR    = 3'd4   // sticky syntax error
    } eval_state_e;

    function automatic logic is_digit(input logic [7:0] c);
        return (c >= CH_0) && (c <= CH_9);
    endfunction

    function automatic logic is_op(input logic [7:0] c);
        return (c == CH_ADD) || (c == CH_MUL);
    endfunction

endpackage

// File: rtl/term_acc.sv
// rtl/term_acc.sv - sum-of-products term accumulator
//
// Holds a running sum, the product currently being built and a pending-multiply flag.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset (highest priority)
//   clear      synchronous clear of all state (used when a '(' opens)
//   opnd_en    apply operand: prod = mul ? prod*opnd : opnd; mul = 0
//   opnd       operand value, W bits
//   op_en      apply operator: '*' sets mul; '+' folds prod into sum
//   op_is_mul  selects '*' (1) or '+' (0) for op_en
//   sum, prod  registered accumulator contents
//   total      sum + prod (value of the term sequence so far)
module term_acc #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         clear,
    input  logic         opnd_en,
    input  logic [W-1:0] opnd,
    input  logic         op_en,
    input  logic         op_is_mul,
    output logic [W-1:0] sum,
    output logic [W-1:0] prod,
    output logic [W-1:0] total
);

    logic [W-1:0] sum_q, sum_d;
    logic [W-1:0] prod_q, prod_d;
    logic         mul_q, mul_d;

    always_comb begin
        sum_d  = sum_q;
        prod_d = prod_q;
        mul_d  = mul_q;
        if (clear) begin
            sum_d  = '0;
            prod_d = '0;
            mul_d  = 1'b0;
        end else if (opnd_en) begin
            // Product truncates to W bits; overflow wraps silently.
            prod_d = mul_q ? prod_q * opnd : opnd;
            mul_d  = 1'b0;
        end else if (op_en) begin
            if (op_is_mul) begin
                mul_d = 1'b1;
            end else begin
                sum_d  = sum_q + prod_q;
                prod_d = '0;
                mul_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            sum_q  <= '0;
            prod_q <= '0;
            mul_q  <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            prod_q <= prod_d;
            mul_q  <= mul_d;
        end
    end

    assign sum   = sum_q;
    assign prod  = prod_q;
    assign total = sum_q + prod_q;

endmodule

// File: rtl/expr_eval.sv
// rtl/expr_eval.sv - streaming arithmetic evaluator for single-digit '+'/'*' expressions
//
// Consumes one ASCII character per cycle with in_valid=1 and tracks the value of the
// consumed prefix. '*' binds tighter than '+'; one level of parentheses is allowed.
// Ports:
//   clk        rising-edge clock
//   clr        synchronous active-high reset; also restarts between expressions
//   in         ASCII character
//   in_valid   character qualifier; registers hold when 0
//   expr_ok    legality bit from the companion checker for the same prefix
//   value      outer sum + outer product of the consumed prefix (W bits, wraps)
//   res_valid  expr_ok & ~err & complete expression (state O_OPR)
//   err        sticky syntax error, cleared only by clr
module expr_eval
    import expr_pkg::*;
#(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr,
    input  logic [7:0]   in,
    input  logic         in_valid,
    input  logic         expr_ok,
    output logic [W-1:0] value,
    output logic         res_valid,
    output logic         err
);

    eval_state_e state_q, state_d;
    logic        err_q, err_d;

    logic         ch_digit;
    logic         ch_op;
    logic         ch_is_mul;
    logic [W-1:0] digit_w;

    logic         o_opnd_en, o_op_en;
    logic [W-1:0] o_opnd;
    logic         i_clear, i_opnd_en, i_op_en;

    logic [W-1:0] o_sum, o_prod, o_total;
    logic [W-1:0] i_sum, i_prod, i_total;
    logic         unused_terms;

    assign ch_digit  = is_digit(in);
    assign ch_op     = is_op(in);
    assign ch_is_mul = (in == CH_MUL);
    // ASCII '0'..'9' are 0x30..0x39, so the low nibble is already the digit value.
    assign digit_w   = {{(W-4){1'b0}}, in[3:0]};

    // The outer accumulator receives either a digit or the closed parenthesised group.
    assign o_opnd = (state_q == I_OPR) ? i_total : digit_w;

    always_comb begin
        state_d   = state_q;
        o_opnd_en = 1'b0;
        o_op_en   = 1'b0;
        i_clear   = 1'b0;
        i_opnd_en = 1'b0;
        i_op_en   = 1'b0;
        if (in_valid) begin
            case (state_q)
                O_OPND: begin
                    if (ch_digit) begin
                        o_opnd_en = 1'b1;
                        state_d   = O_OPR;
                    end else if (in == CH_LP) begin
                        i_clear = 1'b1;
                        state_d = I_OPND;
                    end else begin
                        state_d = ERR;
                    end
                end
                O_OPR: begin
                    if (ch_op) begin
                        o_op_en = 1'b1;
                        state_d = O_OPND;
                    end else begin
                        state_d = ERR;
                    end
                end
                I_OPND: begin
                    if (ch_digit) begin
                        i_opnd_en = 1'b1;
                        state_d   = I_OPR;
                    end else begin
                        state_d = ERR;
                    end
                end
                I_OPR: begin
                    if (ch_op) begin
                        i_op_en = 1'b1;
                        state_d = I_OPND;
                    end else if (in == CH_RP) begin
                        o_opnd_en = 1'b1;
                        state_d   = O_OPR;
                    end else begin
                        state_d = ERR;
                    end
                end
                ERR:     state_d = ERR;
                default: state_d = ERR;
            endcase
        end
        err_d = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= O_OPND;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            err_q   <= err_d;
        end
    end

    term_acc #(.W(W)) u_outer (
        .clk       (clk),
        .clr       (clr),
        .clear     (1'b0),
        .opnd_en   (o_opnd_en),
        .opnd      (o_opnd),
        .op_en     (o_op_en),
        .op_is_mul (ch_is_mul),
        .sum       (o_sum),
        .prod      (o_prod),
        .total     (o_total)
    );

    term_acc #(.W(W)) u_inner (
        .clk       (clk),
        .clr       (clr),
        .clear     (i_clear),
        .opnd_en   (i_opnd_en),
        .opnd      (digit_w),
        .op_en     (i_op_en),
        .op_is_mul (ch_is_mul),
        .sum       (i_sum),
        .prod      (i_prod),
        .total     (i_total)
    );

    // Only the totals are needed here; the split sum/prod views are left unobserved.
    assign unused_terms = ^{o_sum, o_prod, i_sum, i_prod};

    assign value     = o_total;
    assign err       = err_q;
    assign res_valid = expr_ok & ~err_q & (state_q == O_OPR);

endmodule

// File: tb/tb_expr_eval.sv
// tb/tb_expr_eval.sv - self-checking bench for expr_eval (W=16 and W=8 instances)
module tb_expr_eval;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [7:0]  in_ch = 8'h00;
    logic        in_valid = 1'b0;
    logic        expr_ok = 1'b0;
    logic [15:0] value16;
    logic [7:0]  value8;
    logic        rv16, rv8, err16, err8;

    always #5 clk = ~clk;

    expr_eval #(.W(16)) dut16 (
        .clk       (clk),
        .clr       (clr),
        .in        (in_ch),
        .in_valid  (in_valid),
        .expr_ok   (expr_ok),
        .value     (value16),
        .res_valid (rv16),
        .err       (err16)
    );

    expr_eval #(.W(8)) dut8 (
        .clk       (clk),
        .clr       (clr),
        .in        (in_ch),
        .in_valid  (in_valid),
        .expr_ok   (expr_ok),
        .value     (value8),
        .res_valid (rv8),
        .err       (err8)
    );

    // Reference: the accepted legal characters, the length of the longest complete
    // prefix, and the grammar position of the legality checker.
    byte unsigned str[$];
    int  last_complete;
    bit  m_err, m_expect_opnd, m_in_paren;
    int  n_checks = 0;
    int  n_fail = 0;

    function automatic bit is_dig(byte unsigned c);
        return (c >= 8'h30) && (c <= 8'h39);
    endfunction

    function automatic bit model_complete();
        return !m_err && !m_expect_opnd && !m_in_paren;
    endfunction

    function automatic longint unsigned eval_inner(int lo, int hi);
        longint unsigned total = 0;
        longint unsigned term = 1;
        for (int i = lo; i < hi; i++) begin
            if (is_dig(str[i])) term = term * longint'(str[i] - 8'h30);
            else if (str[i] == 8'h2B) begin
                total = total + term;
                term = 1;
            end
        end
        return total + term;
    endfunction

    // Evaluates the first hi characters as an ordinary precedence-respecting expression.
    function automatic longint unsigned eval_prefix(int hi);
        longint unsigned total = 0;
        longint unsigned term = 1;
        int i = 0;
        int j;
        if (hi == 0) return 0;
        while (i < hi) begin
            if (str[i] == 8'h28) begin
                j = i + 1;
                while (str[j] != 8'h29) j++;
                term = term * eval_inner(i + 1, j);
                i = j;
            end else if (is_dig(str[i])) begin
                term = term * longint'(str[i] - 8'h30);
            end else if (str[i] == 8'h2B) begin
                total = total + term;
                term = 1;
            end
            i++;
        end
        return total + term;
    endfunction

    task automatic model_reset();
        str.delete();
        last_complete = 0;
        m_err = 0;
        m_expect_opnd = 1;
        m_in_paren = 0;
    endtask

    task automatic model_accept(byte unsigned c);
        bit legal = 0;
        if (m_err) return;
        if (m_expect_opnd) begin
            if (is_dig(c)) begin
                legal = 1;
                m_expect_opnd = 0;
            end else if (c == 8'h28 && !m_in_paren) begin
                legal = 1;
                m_in_paren = 1;
            end
        end else begin
            if (c == 8'h2B || c == 8'h2A) begin
                legal = 1;
                m_expect_opnd = 1;
            end else if (c == 8'h29 && m_in_paren) begin
                legal = 1;
                m_in_paren = 0;
            end
        end
        if (!legal) begin
            m_err = 1;
        end else begin
            str.push_back(c);
            if (model_complete()) last_complete = str.size();
        end
    endtask

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic step(byte unsigned c, bit v, bit c_clr, bit flip_ok);
        longint unsigned ev;
        @(negedge clk);
        clr = c_clr;
        in_ch = c;
        in_valid = v;
        @(posedge clk);
        if (c_clr) model_reset();
        else if (v) model_accept(c);
        expr_ok = model_complete() ^ flip_ok;
        #1;
        ev = eval_prefix(last_complete);
        chk("value16", {16'h0, value16}, 32'(ev & 64'hFFFF));
        chk("value8", {24'h0, value8}, 32'(ev & 64'hFF));
        chk("res_valid16", {31'h0, rv16}, {31'h0, expr_ok & model_complete()});
        chk("res_valid8", {31'h0, rv8}, {31'h0, expr_ok & model_complete()});
        chk("err16", {31'h0, err16}, {31'h0, m_err});
        chk("err8", {31'h0, err8}, {31'h0, m_err});
    endtask

    task automatic do_clr();
        step(8'h00, 1'b0, 1'b1, 1'b0);
    endtask

    task automatic feed(string s, bit bubbles);
        for (int i = 0; i < s.len(); i++) begin
            step(s[i], 1'b1, 1'b0, 1'b0);
            if (bubbles) step(8'($urandom_range(0, 255)), 1'b0, 1'b0, 1'b0);
        end
    endtask

    initial begin
        model_reset();
        do_clr();
        chk("reset_value", {16'h0, value16}, 32'd0);
        chk("reset_err", {31'h0, err16}, 32'd0);

        feed("2+3*4", 1'b0);
        chk("t1_value", {16'h0, value16}, 32'd14);
        chk("t1_rv", {31'h0, rv16}, 32'd1);

        do_clr();
        feed("(1+2", 1'b0);
        chk("t2_inside_value", {16'h0, value16}, 32'd0);
        chk("t2_inside_rv", {31'h0, rv16}, 32'd0);
        feed(")*3", 1'b0);
        chk("t2_value", {16'h0, value16}, 32'd9);

        do_clr();
        feed("2*(3+4*2)+1", 1'b1);
        chk("t3_value", {16'h0, value16}, 32'd23);

        do_clr();
        feed("2++5", 1'b0);
        chk("t4_err", {31'h0, err16}, 32'd1);
        chk("t4_value", {16'h0, value16}, 32'd2);
        do_clr();
        feed("7", 1'b0);
        chk("t4_restart", {16'h0, value16}, 32'd7);

        do_clr();
        feed("9*9*9*9", 1'b0);
        chk("t5_wrap8", {24'h0, value8}, 32'd161);
        chk("t5_rv8", {31'h0, rv8}, 32'd1);

        do_clr(); feed("((", 1'b0);   chk("t6a_err", {31'h0, err16}, 32'd1);
        do_clr(); feed("(3)(", 1'b0); chk("t6b_err", {31'h0, err16}, 32'd1);
        do_clr(); feed("(3+)", 1'b0); chk("t6c_err", {31'h0, err16}, 32'd1);
        do_clr(); feed("()", 1'b0);   chk("t6d_err", {31'h0, err16}, 32'd1);

        // clr in the middle of a group must leave no inner residue.
        do_clr(); feed("(9*9", 1'b0); do_clr(); feed("(2)", 1'b0);
        chk("t7_value", {16'h0, value16}, 32'd2);

        do_clr();
        for (int n = 0; n < 1500; n++) begin
            byte unsigned c;
            bit v, cl, fl;
            if ($urandom_range(0, 9) == 0) begin
                c = 8'($urandom_range(0, 255));
            end else if (m_expect_opnd) begin
                if (!m_in_paren && $urandom_range(0, 4) == 0) c = 8'h28;
                else c = 8'(8'h30 + $urandom_range(0, 9));
            end else begin
                if (m_in_paren && $urandom_range(0, 2) == 0) c = 8'h29;
                else c = ($urandom_range(0, 1) == 0) ? 8'h2B : 8'h2A;
            end
            v  = ($urandom_range(0, 9) != 0);
            cl = ($urandom_range(0, 39) == 0) || (m_err && $urandom_range(0, 3) == 0)
                 || (str.size() > 40);
            fl = ($urandom_range(0, 9) == 0);
            step(c, v, cl, fl);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
        $finish;
    end

endmodule
